// File: rtl/load_use_interlock_pkg.sv
// load_use_interlock_pkg: opcodes, FSM state encoding and default widths for the load-use interlock
package load_use_interlock_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int OP_W_DEF = 7;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RELEASE} state_t;
endpackage

// File: rtl/load_use_interlock_wait_timer.sv
// interlock_wait_timer: 16-bit saturating MEM-wait counter; hit flags the cycle the count reaches TIMEOUT
module interlock_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam logic [16:0] LIM = 17'(TIMEOUT);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && {1'b0, cnt} != LIM) cnt <= cnt + 16'd1;
  assign hit = en && ({1'b0, cnt} + 17'd1 >= LIM);
endmodule

// File: rtl/load_use_interlock.sv
// load_use_interlock: load-use hazard stall/bubble plus MEM-wait hold with sticky timeout (INTERLOCK_STATS_EN adds stall_cycles)
module load_use_interlock
  import load_use_interlock_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [OP_W-1:0]   ex_op,
  input  logic              mem_load_req,
  input  logic              mem_ack,
  input  logic              flush,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              stall_mem,
  output logic              busy,
  output logic              timeout_err
`ifdef INTERLOCK_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  state_t state;
  logic hz, wait_st, hit;
  assign hz = id_valid && ex_valid && ex_op == OP_W'(OP_LOAD) && ex_rd != '0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign wait_st = state == LOAD_WAIT;
  assign stall_if = rst_n && !flush && (wait_st || hz);
  assign stall_id = stall_if;
  assign bubble_ex = rst_n && (flush || (!wait_st && hz));
  assign stall_mem = wait_st;
  assign busy = state != IDLE;
  interlock_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!wait_st),
    .en(wait_st),
    .hit(hit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timeout_err <= 1'b0;
    end else if (wait_st) begin
      state <= mem_ack ? RELEASE : LOAD_WAIT;
      if (hit && !mem_ack) timeout_err <= 1'b1;
    end else begin
      state <= (mem_load_req && !mem_ack) ? LOAD_WAIT : IDLE;
    end
`ifdef INTERLOCK_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if ((stall_if || stall_mem) && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_load_use_interlock.sv
// tb_load_use_interlock: scoreboard-driven bench for the load-use interlock with TIMEOUT=4
module tb_load_use_interlock;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, ex_valid, mem_load_req, mem_ack, flush;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [6:0] ex_op;
  logic stall_if, stall_id, bubble_ex, stall_mem, busy, timeout_err;
`ifdef INTERLOCK_STATS_EN
  logic [31:0] stall_cycles;
`endif
  logic [5:0] outv;
  logic [5:0] sb[$];
  int total = 0;
  int passed = 0;

  load_use_interlock #(.REG_AW(5), .OP_W(7), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid),
    .ex_rd(ex_rd),
    .ex_op(ex_op),
    .mem_load_req(mem_load_req),
    .mem_ack(mem_ack),
    .flush(flush),
    .stall_if(stall_if),
    .stall_id(stall_id),
    .bubble_ex(bubble_ex),
    .stall_mem(stall_mem),
    .busy(busy),
    .timeout_err(timeout_err)
`ifdef INTERLOCK_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  assign outv = {stall_if, stall_id, bubble_ex, stall_mem, busy, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0;
    mem_load_req = 0; mem_ack = 0; flush = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_op = 0;
  endtask

  task automatic set_hz();
    id_valid = 1; ex_valid = 1; ex_op = 7'b0000011; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    set_hz();
    flush = 1;
    #1;
    sb.push_back(6'b000000);
    e = sb.pop_front(); total++;
    if (outv !== e) $display("FAIL reset_async got %b want %b", outv, e); else passed++;
    sb.push_back(6'b000000);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (outv !== e) $display("FAIL reset_held got %b want %b", outv, e); else passed++;
    tick();
    idle_in();
    rst_n = 1;
    tick();
  endtask

  task automatic test_hazard();
    logic [5:0] e;
    int v[7]  = '{1, 1, 1, 1, 1, 0, 1};
    int r1[7] = '{5, 0, 0, 5, 0, 5, 9};
    int u1[7] = '{1, 1, 0, 1, 0, 1, 1};
    int r2[7] = '{0, 0, 7, 0, 7, 0, 9};
    int u2[7] = '{0, 0, 0, 0, 1, 0, 1};
    int rd[7] = '{5, 0, 7, 5, 7, 5, 8};
    int ld[7] = '{1, 1, 1, 0, 1, 1, 1};
    int hz_exp[7] = '{1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      idle_in();
      id_valid = v[i][0]; ex_valid = 1;
      id_rs1 = 5'(r1[i]); id_use_rs1 = u1[i][0];
      id_rs2 = 5'(r2[i]); id_use_rs2 = u2[i][0];
      ex_rd = 5'(rd[i]); ex_op = ld[i][0] ? 7'b0000011 : 7'b0110011;
      sb.push_back(hz_exp[i][0] ? 6'b111000 : 6'b000000);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL hazard case%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_load_wait();
    logic [5:0] e;
    int rq[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int ak[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
    logic [5:0] ex[10] = '{6'b000000, 6'b110110, 6'b110110, 6'b110110, 6'b000010,
                            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 10; i++) begin
      idle_in();
      mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL load_wait c%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    int rq[6] = '{1, 0, 1, 0, 0, 0};
    int ak[6] = '{0, 1, 0, 1, 0, 0};
    logic [5:0] ex[6] = '{6'b000000, 6'b110110, 6'b000010, 6'b110110, 6'b000010, 6'b000000};
    for (int i = 0; i < 6; i++) begin
      idle_in();
      mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL back_to_back c%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_flush();
    logic [5:0] e;
    int hz[8] = '{1, 0, 0, 0, 0, 1, 1, 0};
    int fl[8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    int rq[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int ak[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    logic [5:0] ex[8] = '{6'b001000, 6'b000000, 6'b001110, 6'b110110,
                           6'b110110, 6'b001010, 6'b111000, 6'b000000};
    for (int i = 0; i < 8; i++) begin
      idle_in();
      if (hz[i] != 0) set_hz();
      flush = fl[i][0]; mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL flush c%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_ack_at_timeout();
    logic [5:0] e;
    int rq[7] = '{1, 0, 0, 0, 0, 0, 0};
    int ak[7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [5:0] ex[7] = '{6'b000000, 6'b110110, 6'b110110, 6'b110110,
                           6'b110110, 6'b000010, 6'b000000};
    for (int i = 0; i < 7; i++) begin
      idle_in();
      mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL ack_at_timeout c%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    int rq[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int ak[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [5:0] ex[11] = '{6'b000000, 6'b110110, 6'b110110, 6'b110110, 6'b110110, 6'b110111,
                            6'b110111, 6'b000011, 6'b000001, 6'b000001, 6'b110111};
    for (int i = 0; i < 11; i++) begin
      idle_in();
      mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (outv !== e) $display("FAIL timeout c%0d got %b want %b", i, outv, e); else passed++;
      tick();
    end
    idle_in();
    set_hz();
    #2;
    rst_n = 0;
    #1;
    sb.push_back(6'b000000);
    e = sb.pop_front(); total++;
    if (outv !== e) $display("FAIL reset_mid_wait got %b want %b", outv, e); else passed++;
    tick();
    idle_in();
    rst_n = 1;
    sb.push_back(6'b000000);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (outv !== e) $display("FAIL after_reset_idle got %b want %b", outv, e); else passed++;
    tick();
  endtask

`ifdef INTERLOCK_STATS_EN
  task automatic test_stats();
    int rq[6] = '{0, 1, 0, 0, 0, 0};
    int ak[6] = '{0, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_in();
      if (i == 0) set_hz();
      mem_load_req = rq[i][0]; mem_ack = ak[i][0];
      tick();
    end
    idle_in();
    @(negedge clk);
    total++;
    if (stall_cycles !== 32'd4) $display("FAIL stall_cycles got %0d want 4", stall_cycles); else passed++;
    tick();
  endtask
`endif

  initial begin
    idle_in();
    test_reset();
    test_hazard();
    test_load_wait();
    test_back_to_back();
    test_flush();
    test_ack_at_timeout();
    test_timeout();
`ifdef INTERLOCK_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
